// File: rtl/add_share_pkg.sv
// Shared types and helpers for the add_share_sched adder-sharing scheduler.
package add_share_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_e;

    // First set bit of req at or above ptr, wrapping modulo n (n <= 8).
    // Returns ptr when req is empty; callers qualify with |req.
    function automatic int rr_next_f(input int ptr, input logic [7:0] req, input int n);
        int  g;
        int  idx;
        bit  found;
        g     = ptr;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && i < n) begin
                idx = (ptr + i) % n;
                if (req[idx]) begin
                    g     = idx;
                    found = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/add_share_rr_arb.sv
// Combinational round-robin select; the caller owns and advances the pointer.
module add_share_rr_arb
    import add_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int ID_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic [ID_W-1:0] o_grant,
    output logic            o_any
);

    logic [7:0] req_ext;

    // Pick the first requester at or above the pointer, wrapping.
    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = i_req;
        o_grant             = ID_W'(rr_next_f(int'(i_ptr), req_ext, NREQ));
        o_any               = |i_req;
    end

endmodule

// File: rtl/adder_32b_param.sv
// Plain ripple/behavioural adder shared by the scheduler; width defaults to 32.
module adder_32b_param #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_carry,
    output logic [W-1:0] o_sum,
    output logic         o_carry
);

    // Carry-out is the top bit of a one-bit-wider sum.
    always_comb begin
        {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + (W+1)'(i_carry);
    end

endmodule

// File: rtl/add_share_sched.sv
// Round-robin scheduler sharing one 32-bit adder among NREQ packet streams.
// Optional macro ADD_SHARE_OVF_CNT_EN adds o_res_ovf, a per-packet count of
// beats whose running sum wrapped past 2^32.
module add_share_sched
    import add_share_pkg::*;
#(
    parameter  int NREQ   = 4,
    parameter  int MAXOPS = 8,
    localparam int ID_W   = $clog2(NREQ),
    localparam int CNT_W  = $clog2(MAXOPS) + 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NREQ-1:0]        i_req_valid,
    input  logic [NREQ*DATA_W-1:0] i_req_data,
    input  logic [NREQ-1:0]        i_req_last,
    output logic [NREQ-1:0]        o_req_ready,
    output logic                   o_res_valid,
    output logic [DATA_W-1:0]      o_res_data,
    output logic [ID_W-1:0]        o_res_id,
    output logic                   o_res_err,
`ifdef ADD_SHARE_OVF_CNT_EN
    output logic [CNT_W-1:0]       o_res_ovf,
`endif
    input  logic                   i_res_ready,
    output logic                   o_busy
);

    state_e              state_q, state_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]    opcnt_q, opcnt_d;
    logic                res_valid_q, res_valid_d;
    logic                res_err_q, res_err_d;
    logic [CNT_W-1:0]    ovf_q, ovf_d;

    logic [ID_W-1:0]     arb_grant;
    logic                arb_any;
    logic [DATA_W-1:0]   beat_data;
    logic [DATA_W-1:0]   sum;
    logic                carry_unused;
    logic                beat;
    logic                beat_last;

    add_share_rr_arb #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (rr_ptr_q),
        .o_grant (arb_grant),
        .o_any   (arb_any)
    );

    adder_32b_param #(.W(DATA_W)) u_add (
        .i_a     (acc_q),
        .i_b     (beat_data),
        .i_carry (1'b0),
        .o_sum   (sum),
        .o_carry (carry_unused)
    );

    // Granted lane's operand/handshake; ready is only ever offered in ACC.
    always_comb begin
        beat_data               = i_req_data[DATA_W*int'(grant_q) +: DATA_W];
        o_req_ready             = '0;
        if (state_q == ACC) o_req_ready[grant_q] = 1'b1;
        beat                    = (state_q == ACC) && i_req_valid[grant_q];
        beat_last               = i_req_last[grant_q];
    end

    // Next-state: arbitrate, accumulate until last/MAXOPS, hold result until taken.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        acc_d       = acc_q;
        opcnt_d     = opcnt_q;
        res_valid_d = res_valid_q;
        res_err_d   = res_err_q;
        ovf_d       = ovf_q;
        case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_grant;
                    acc_d   = '0;
                    opcnt_d = '0;
                    ovf_d   = '0;
                    state_d = ACC;
                end
            end
            ACC: begin
                if (beat) begin
                    acc_d   = sum;
                    opcnt_d = opcnt_q + CNT_W'(1);
                    if (sum < acc_q) ovf_d = ovf_q + CNT_W'(1);
                    if (beat_last) begin
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b0;
                    end else if (opcnt_q == CNT_W'(MAXOPS - 1)) begin
                        // Truncate: the tail of this packet comes back as a new one.
                        state_d     = RESP;
                        res_valid_d = 1'b1;
                        res_err_d   = 1'b1;
                    end
                end
            end
            RESP: begin
                if (i_res_ready) begin
                    res_valid_d = 1'b0;
                    rr_ptr_d    = ID_W'((int'(grant_q) + 1) % NREQ);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            acc_q       <= '0;
            opcnt_q     <= '0;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            ovf_q       <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            acc_q       <= acc_d;
            opcnt_q     <= opcnt_d;
            res_valid_q <= res_valid_d;
            res_err_q   <= res_err_d;
            ovf_q       <= ovf_d;
        end
    end

    // acc holds the finished sum throughout RESP, so it doubles as the result.
    assign o_res_valid = res_valid_q;
    assign o_res_data  = acc_q;
    assign o_res_id    = grant_q;
    assign o_res_err   = res_err_q;
    assign o_busy      = (state_q != IDLE);
`ifdef ADD_SHARE_OVF_CNT_EN
    assign o_res_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_add_share_sched.sv
// Self-checking bench for add_share_sched: packet-level model plus directed cases.
module tb_add_share_sched;

    localparam int NREQ   = 4;
    localparam int MAXOPS = 8;
    localparam int ID_W   = $clog2(NREQ);
    localparam int CNT_W  = $clog2(MAXOPS) + 1;

    logic                 i_clk = 1'b0;
    logic                 i_rst_n;
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ*32-1:0]   i_req_data;
    logic [NREQ-1:0]      i_req_last;
    logic [NREQ-1:0]      o_req_ready;
    logic                 o_res_valid;
    logic [31:0]          o_res_data;
    logic [ID_W-1:0]      o_res_id;
    logic                 o_res_err;
    logic                 i_res_ready;
    logic                 o_busy;
`ifdef ADD_SHARE_OVF_CNT_EN
    logic [CNT_W-1:0]     o_res_ovf;
`endif

    add_share_sched #(.NREQ(NREQ), .MAXOPS(MAXOPS)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_res_valid (o_res_valid),
        .o_res_data  (o_res_data),
        .o_res_id    (o_res_id),
        .o_res_err   (o_res_err),
`ifdef ADD_SHARE_OVF_CNT_EN
        .o_res_ovf   (o_res_ovf),
`endif
        .i_res_ready (i_res_ready),
        .o_busy      (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] data; bit last; int gap; } beat_t;
    typedef struct { logic [31:0] data; bit err; int ovf; int id; } res_t;

    beat_t       bq[NREQ][$];
    res_t        exp_q[NREQ][$];
    res_t        res_log[$];
    logic [31:0] macc[NREQ];
    int          mcnt[NREQ];
    int          movf[NREQ];
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          exp_vld_next = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] d, input bit last, input int gap);
        beat_t b;
        b.data = d; b.last = last; b.gap = gap;
        bq[k].push_back(b);
    endtask

    task automatic model_clear();
        for (int k = 0; k < NREQ; k++) begin
            macc[k] = '0; mcnt[k] = 0; movf[k] = 0;
            exp_q[k].delete();
            bq[k].delete();
        end
        exp_vld_next = 1'b0;
    endtask

    // Packet-level model: sum mod 2^32, close on last or on the MAXOPS-th beat.
    task automatic model_beat(input int k, input beat_t b);
        logic [32:0] s;
        res_t        r;
        s = {1'b0, macc[k]} + {1'b0, b.data};
        if (s[32]) movf[k]++;
        macc[k] = s[31:0];
        mcnt[k]++;
        if (b.last || mcnt[k] == MAXOPS) begin
            r.data = macc[k]; r.err = !b.last; r.ovf = movf[k]; r.id = k;
            exp_q[k].push_back(r);
            macc[k] = '0; mcnt[k] = 0; movf[k] = 0;
            exp_vld_next = 1'b1;
        end
    endtask

    // Requester driver: present queue heads after negedge, retire beats that handshook.
    initial begin
        logic [NREQ-1:0] hs;
        beat_t           b;
        i_req_valid = '0; i_req_data = '0; i_req_last = '0;
        forever begin
            @(negedge i_clk);
            for (int k = 0; k < NREQ; k++) begin
                i_req_valid[k] = 1'b0;
                i_req_last[k]  = 1'b0;
                if (bq[k].size() > 0) begin
                    if (bq[k][0].gap > 0) begin
                        b = bq[k][0]; b.gap = b.gap - 1; bq[k][0] = b;
                    end else begin
                        i_req_valid[k]          = 1'b1;
                        i_req_data[32*k +: 32]  = bq[k][0].data;
                        i_req_last[k]           = bq[k][0].last;
                    end
                end
            end
            #3;
            hs = i_req_valid & o_req_ready & {NREQ{i_rst_n}};
            @(posedge i_clk);
            #1;
            if (i_rst_n) begin
                for (int k = 0; k < NREQ; k++)
                    if (hs[k] && bq[k].size() > 0) model_beat(k, bq[k].pop_front());
            end
        end
    end

    // Compare process: every cycle a result is presented, check it against the model.
    initial begin
        int   id;
        res_t r;
        forever begin
            @(negedge i_clk);
            #2;
            if (i_rst_n) begin
                if (exp_vld_next) begin
                    chk("res_valid_latency", 64'(o_res_valid), 64'd1);
                    exp_vld_next = 1'b0;
                end
                if (o_res_valid) begin
                    id = int'(o_res_id);
                    chk("busy_in_resp", 64'(o_busy), 64'd1);
                    chk("ready_in_resp", 64'(o_req_ready), 64'd0);
                    if (exp_q[id].size() == 0) begin
                        n_tests++; n_fail++;
                        $display("FAIL unexpected_result: id %0d data 0x%0h, none expected", id, o_res_data);
                    end else begin
                        chk("res_data", 64'(o_res_data), 64'(exp_q[id][0].data));
                        chk("res_err", 64'(o_res_err), 64'(exp_q[id][0].err));
`ifdef ADD_SHARE_OVF_CNT_EN
                        chk("res_ovf", 64'(o_res_ovf), 64'(exp_q[id][0].ovf));
`endif
                    end
                    if (i_res_ready) begin
                        r.data = o_res_data; r.err = o_res_err; r.id = id; r.ovf = 0;
`ifdef ADD_SHARE_OVF_CNT_EN
                        r.ovf = int'(o_res_ovf);
`endif
                        res_log.push_back(r);
                        if (exp_q[id].size() > 0) void'(exp_q[id].pop_front());
                    end
                end
            end
        end
    end

    task automatic wait_results(input int n, input int budget, input string name);
        int c = 0;
        while (res_log.size() < n && c < budget) begin
            @(posedge i_clk);
            c++;
        end
        if (res_log.size() < n) begin
            n_tests++; n_fail++;
            $display("FAIL %s_timeout: got %0d results expected %0d", name, res_log.size(), n);
        end
    endtask

    task automatic chk_log(input int i, input string name, input logic [31:0] d, input int id, input bit err);
        if (res_log.size() <= i) begin
            n_tests++; n_fail++;
            $display("FAIL %s_missing: got %0d results expected index %0d", name, res_log.size(), i);
        end else begin
            chk({name, "_data"}, 64'(res_log[i].data), 64'(d));
            chk({name, "_id"},   64'(res_log[i].id),   64'(id));
            chk({name, "_err"},  64'(res_log[i].err),  64'(err));
        end
    endtask

    task automatic do_reset();
        @(negedge i_clk);
        i_rst_n = 1'b0;
        model_clear();
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    initial begin
        int c;
        logic [31:0] held;
        i_rst_n     = 1'b0;
        i_res_ready = 1'b1;
        model_clear();
        #12;
        chk("rst_ready", 64'(o_req_ready), 64'd0);
        chk("rst_valid", 64'(o_res_valid), 64'd0);
        chk("rst_data",  64'(o_res_data),  64'd0);
        chk("rst_id",    64'(o_res_id),    64'd0);
        chk("rst_err",   64'(o_res_err),   64'd0);
        chk("rst_busy",  64'(o_busy),      64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Two SHA-256 constants, last on the second beat.
        push(0, 32'h6a09e667, 1'b0, 0);
        push(0, 32'h428a2f98, 1'b1, 0);
        wait_results(1, 50, "basic");
        chk_log(0, "basic", 32'hac9415ff, 0, 1'b0);

        // Unsigned wrap.
        push(2, 32'hffffffff, 1'b0, 0);
        push(2, 32'h00000002, 1'b1, 0);
        wait_results(2, 50, "wrap");
        chk_log(1, "wrap", 32'h00000001, 2, 1'b0);
`ifdef ADD_SHARE_OVF_CNT_EN
        if (res_log.size() > 1) chk("wrap_ovf", 64'(res_log[1].ovf), 64'd1);
`endif

        // Arbitration from rr_ptr=0: 1 before 3.
        do_reset();
        push(1, 32'h11, 1'b1, 0);
        push(3, 32'h33, 1'b1, 0);
        wait_results(4, 50, "arb13");
        chk_log(2, "arb_first", 32'h11, 1, 1'b0);
        chk_log(3, "arb_second", 32'h33, 3, 1'b0);
        // Serve 1 alone (pointer moves to 2), then 1 and 2 together: 2 wins.
        push(1, 32'h100, 1'b1, 0);
        wait_results(5, 50, "arb1");
        chk_log(4, "arb_solo", 32'h100, 1, 1'b0);
        push(1, 32'h200, 1'b1, 0);
        push(2, 32'h300, 1'b1, 0);
        wait_results(7, 50, "arb21");
        chk_log(5, "arb_rr_first", 32'h300, 2, 1'b0);
        chk_log(6, "arb_rr_second", 32'h200, 1, 1'b0);

        // MAXOPS truncation: 9 beats of 1 -> 8 with err, then 1 without.
        for (int i = 0; i < 9; i++) push(0, 32'h1, (i == 8), 0);
        wait_results(9, 100, "maxops");
        chk_log(7, "trunc", 32'h8, 0, 1'b1);
        chk_log(8, "tail", 32'h1, 0, 1'b0);

        // Back-pressure with valid gaps mid-packet; a rival request waits.
        @(negedge i_clk);
        i_res_ready = 1'b0;
        push(3, 32'd10, 1'b0, 0);
        push(3, 32'd20, 1'b0, 2);
        push(3, 32'd30, 1'b1, 3);
        c = 0;
        while (!o_res_valid && c < 60) begin @(negedge i_clk); c++; end
        chk("bp_valid_seen", 64'(o_res_valid), 64'd1);
        push(1, 32'h7, 1'b1, 0);
        held = o_res_data;
        chk("bp_sum", 64'(held), 64'h3c);
        repeat (5) begin
            @(negedge i_clk);
            #2;
            chk("bp_valid_hold", 64'(o_res_valid), 64'd1);
            chk("bp_data_hold",  64'(o_res_data),  64'(held));
            chk("bp_ready_zero", 64'(o_req_ready), 64'd0);
        end
        @(negedge i_clk);
        i_res_ready = 1'b1;
        wait_results(11, 60, "bp");
        chk_log(9, "bp_res", 32'h3c, 3, 1'b0);
        chk_log(10, "bp_next", 32'h7, 1, 1'b0);

        // Reset mid-packet after three beats; partial sum must vanish.
        push(0, 32'h5, 1'b0, 0);
        push(0, 32'h6, 1'b0, 0);
        push(0, 32'h7, 1'b0, 0);
        c = 0;
        while (bq[0].size() > 0 && c < 40) begin @(negedge i_clk); c++; end
        repeat (2) @(negedge i_clk);
        #2;
        chk("stall_busy", 64'(o_busy), 64'd1);
        chk("stall_ready", 64'(o_req_ready), 64'b0001);
        i_rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_ready", 64'(o_req_ready), 64'd0);
        chk("arst_valid", 64'(o_res_valid), 64'd0);
        chk("arst_data",  64'(o_res_data),  64'd0);
        chk("arst_id",    64'(o_res_id),    64'd0);
        chk("arst_err",   64'(o_res_err),   64'd0);
        chk("arst_busy",  64'(o_busy),      64'd0);
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        push(0, 32'h5, 1'b0, 0);
        push(0, 32'h7, 1'b1, 0);
        wait_results(12, 50, "post_rst");
        chk_log(11, "post_rst", 32'hc, 0, 1'b0);

        repeat (3) @(negedge i_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/add_share_sched.md
Name: add_share_sched

Overview:
- Round-robin scheduler that shares one 32-bit adder (adder_32b_param, i_carry tied 0) among NREQ requesters.
- Each requester streams a packet of 1..MAXOPS operands. The block accumulates them mod 2^32 and returns one tagged sum.
- Sits between the SHA-256 round/schedule logic (T1/T2, W[t] sums) and the single adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAXOPS, 8, maximum operands per packet (2..16).
- ID_W, $clog2(NREQ), width of the result tag (localparam, not overridable).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_req_valid  in  NREQ  per-requester operand valid.
- i_req_data  in  NREQ*32  operands; requester k occupies bits [32k+31:32k].
- i_req_last  in  NREQ  marks the final operand of a packet.
- o_req_ready  out  NREQ  per-requester operand accept.
- o_res_valid  out  1  result valid.
- o_res_data  out  32  accumulated sum mod 2^32.
- o_res_id  out  ID_W  index of the requester that owns the result.
- o_res_err  out  1  packet truncated at MAXOPS.
- i_res_ready  in  1  result consumer ready.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous assert, active-low.
- Reset values: state=IDLE, rr_ptr=0, acc=0, opcnt=0, o_req_ready=0, o_res_valid=0, o_res_data=0, o_res_id=0, o_res_err=0, o_busy=0.
- States: IDLE, ACC, RESP.
- IDLE:
  - If any i_req_valid is high, grant = first set bit searching upward from rr_ptr, wrapping modulo NREQ.
  - Register grant, clear acc and opcnt, go to ACC.
  - Arbitration costs exactly 1 cycle.
- ACC:
  - o_req_ready[grant]=1; all other ready bits are 0. Ready is combinational from state and grant.
  - A beat is accepted when valid&ready. On each beat: acc <= adder(acc, data), opcnt++.
  - If valid drops mid-packet, the block stalls in ACC indefinitely, with no timeout. Non-granted requesters hold their data.
  - An accepted beat with last=1 goes to RESP, o_res_err=0.
  - When the MAXOPS-th beat is accepted with last=0, go to RESP with o_res_err=1. Remaining beats of that packet are treated as a new packet at a later grant. The requester is responsible for discarding them.
- RESP:
  - o_res_valid=1; o_res_data, o_res_id and o_res_err are stable while valid.
  - On i_res_ready: o_res_valid <= 0, rr_ptr <= grant+1 mod NREQ, go to IDLE.
  - o_res_valid holds until accepted. No beats are accepted in RESP.
- Latency: the result is valid on the cycle after the last beat. A single-operand packet returns the operand unchanged.
- Arithmetic: unsigned, mod 2^32. The adder's o_carry is ignored.
- Fairness: a requester holding valid is granted within NREQ-1 packets of the other requesters.
- Simultaneous events: valid asserted in RESP is not seen until IDLE. A new request arriving in the same cycle as i_res_ready is arbitrated next cycle with the updated rr_ptr.
- Reset mid-packet: returns to reset values immediately. The partial packet is lost.

Optional Feature:
- Macro ADD_SHARE_OVF_CNT_EN.
- With the macro:
  - Extra output o_res_ovf [$clog2(MAXOPS):0] counts the beats in which adder_sum < acc (unsigned wrap), computed locally and independent of the adder variant.
  - Cleared at grant, valid with o_res_valid, reset value 0.
- Without the macro: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Shared package add_share_pkg:
  - state enum {IDLE, ACC, RESP}.
  - DATA_W=32.
  - rr_next_f(ptr, req) function returning the grant index.
- One sub-module: add_share_rr_arb (combinational round-robin select: req vector + ptr -> grant index + any). The scheduler owns ptr.
- The adder is instantiated directly as adder_32b_param.

Test Plan:
- Single requester 0, operands 0x6a09e667, 0x428a2f98, last on the 2nd beat -> o_res_data=0xac9415ff, o_res_id=0, err=0. o_res_valid rises 1 cycle after the last beat.
- Requesters 1 and 3 valid together with rr_ptr=0 -> grant 1 first, then 3 after the RESP handshake. Then requester 1 again with requester 2 pending -> 2 is granted before 1.
- Wrap: 0xffffffff + 0x00000002 -> 0x00000001. With ADD_SHARE_OVF_CNT_EN, o_res_ovf=1.
- MAXOPS=8, packet of 9 beats each 0x1 -> first result 0x8 with err=1; the 9th beat alone -> 0x1 with err=0.
- Back-pressure: hold i_res_ready=0 for 5 cycles -> o_res_valid and data stay stable, all o_req_ready=0. Insert valid gaps mid-packet -> the sum is unaffected.
- Assert i_rst_n=0 mid-ACC after 3 beats -> all outputs 0 asynchronously. After release, a new packet 0x5, 0x7 -> 0xc with no residue.
